// File: rtl/fetch_predictor.sv
// fetch_predictor: PC register, I-mem addressing, next-PC prediction and IF/ID register.
// Define FETCH_BP_EN to build the 2-bit counter BHT; without it only JAL predicts taken.
module fetch_predictor #(
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_ex_br_vld,
    input  logic [31:0] i_ex_br_pc,
    input  logic        i_ex_br_taken,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_pc,
    output logic        o_vld
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [31:0] pc, jal_imm, br_imm, pred_next, next_pc;
    logic        is_jal, is_br, bht_taken, pred_taken;

    assign o_imem_addr = pc;
    assign is_jal      = i_imem_rdata[6:2] == 5'b11011;
    assign is_br       = i_imem_rdata[6:2] == 5'b11000;
    assign jal_imm     = {{11{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[19:12],
                          i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
    assign br_imm      = {{19{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[7],
                          i_imem_rdata[30:25], i_imem_rdata[11:8], 1'b0};
    assign pred_taken  = is_jal | (is_br & bht_taken);
    assign pred_next   = pc + (is_jal ? jal_imm : (is_br & bht_taken) ? br_imm : 32'd4);
    assign next_pc     = i_ex_redirect ? i_ex_redirect_pc : i_stall ? pc : pred_next;

`ifdef FETCH_BP_EN
    logic [1:0]     bht [BHT_ENTRIES];
    logic [IDX-1:0] tr_idx;
    logic [1:0]     tr_cnt;
    logic           unused_br_pc;

    assign tr_idx       = i_ex_br_pc[IDX+1:2];
    assign tr_cnt       = bht[tr_idx];
    assign bht_taken    = bht[pc[IDX+1:2]][1];
    assign unused_br_pc = ^{i_ex_br_pc[31:IDX+2], i_ex_br_pc[1:0]};

    // Training ignores stall/redirect; a same-index read this cycle still sees the old count.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        else if (i_ex_br_vld)
            bht[tr_idx] <= i_ex_br_taken ? ((tr_cnt == 2'b11) ? tr_cnt : tr_cnt + 2'd1)
                                         : ((tr_cnt == 2'b00) ? tr_cnt : tr_cnt - 2'd1);
    end
`else
    logic unused_br;

    assign unused_br = ^{i_ex_br_vld, i_ex_br_pc, i_ex_br_taken};
    assign bht_taken = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        pc <= i_reset ? RESET_PC : next_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_instr      <= 32'h0;
            o_vld        <= 1'b0;
            o_pred_taken <= 1'b0;
            o_pc         <= RESET_PC;
            o_pred_pc    <= RESET_PC + 32'd4;
        end else if (i_ex_redirect) begin
            o_instr      <= 32'h0;
            o_vld        <= 1'b0;
            o_pred_taken <= 1'b0;
        end else if (!i_stall) begin
            o_instr      <= i_imem_rdata;
            o_vld        <= 1'b1;
            o_pred_taken <= pred_taken;
            o_pc         <= pc;
            o_pred_pc    <= pred_next;
        end
    end
endmodule

// File: tb/tb_fetch_predictor.sv
// tb_fetch_predictor: random fetch/stall/redirect/training traffic checked by a scoreboard
// against a behavioural model of the fetch rules (BHT modelled only when FETCH_BP_EN is defined).
module tb_fetch_predictor;
    localparam int          BHT   = 64;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          NCYC  = 3000;

    typedef struct packed {
        logic [31:0] instr, pc, pred_pc, addr;
        logic        taken, vld, pc_dc;
    } exp_t;

    logic        clk = 0, rst = 1, stall = 0, br_vld = 0, br_taken = 0, redirect = 0;
    logic [31:0] imem_addr, imem_rdata, br_pc = 0, redirect_pc = 0;
    logic [31:0] instr, pc, pred_pc;
    logic        pred_taken, vld;
    logic [31:0] mem [256];
    exp_t        q[$];
    int          n_vec = 0, n_bad = 0;

    fetch_predictor #(.BHT_ENTRIES(BHT), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_reset(rst), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .i_stall(stall), .i_ex_br_vld(br_vld), .i_ex_br_pc(br_pc), .i_ex_br_taken(br_taken),
        .i_ex_redirect(redirect), .i_ex_redirect_pc(redirect_pc), .o_instr(instr), .o_pc(pc),
        .o_pred_taken(pred_taken), .o_pred_pc(pred_pc), .o_vld(vld)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[9:2]];

    function automatic logic [31:0] jal_target(input logic [31:0] p, input logic [31:0] w);
        int off;
        off = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        return p + 32'(off);
    endfunction

    function automatic logic [31:0] br_target(input logic [31:0] p, input logic [31:0] w);
        int off;
        off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        return p + 32'(off);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (instr !== e.instr || vld !== e.vld || pred_taken !== e.taken || imem_addr !== e.addr ||
                (!e.pc_dc && (pc !== e.pc || pred_pc !== e.pred_pc))) begin
                n_bad++;
                $display("FAIL ifid t=%0t got instr=%h vld=%b tk=%b pc=%h ppc=%h addr=%h required instr=%h vld=%b tk=%b pc=%h ppc=%h addr=%h dc=%b",
                         $time, instr, vld, pred_taken, pc, pred_pc, imem_addr,
                         e.instr, e.vld, e.taken, e.pc, e.pred_pc, e.addr, e.pc_dc);
            end
        end
    end

    initial begin
        int          ctr [BHT];
        exp_t        cur;
        logic [31:0] pc_m, w, pn, r;
        logic        pt;
        for (int i = 0; i < 256; i++) begin
            r = $urandom();
            case ($urandom_range(9))
                0, 1, 2: mem[i] = {r[31:7], 7'b0010011};
                3, 4:    mem[i] = {r[31:7], 7'b1101111};
                5, 6:    mem[i] = {r[31:7], 7'b1100011};
                7:       mem[i] = {r[31:7], 7'b1100111};
                default: mem[i] = r;
            endcase
            if (i >= 16 && i < 32) mem[i] = {r[31:7], 7'b1100011};
        end
        cur  = '0;
        pc_m = RPC;
        for (int i = 0; i < BHT; i++) ctr[i] = 1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst         = (c < 2) || ($urandom_range(99) < 2);
            redirect    = $urandom_range(99) < 10;
            redirect_pc = $urandom_range(1) ? 32'h40 + 32'($urandom_range(15)) * 4 : 32'($urandom_range(255)) * 4;
            stall       = $urandom_range(99) < 25;
            br_vld      = $urandom_range(99) < 40;
            br_pc       = 32'h40 + 32'($urandom_range(15)) * 4;
            br_taken    = $urandom_range(99) < 60;
            w  = mem[pc_m[9:2]];
            pt = 1'b0;
            pn = pc_m + 4;
            if (w[6:2] == 5'b11011) begin
                pt = 1'b1;
                pn = jal_target(pc_m, w);
            end
`ifdef FETCH_BP_EN
            else if (w[6:2] == 5'b11000 && ctr[(pc_m / 4) % BHT] >= 2) begin
                pt = 1'b1;
                pn = br_target(pc_m, w);
            end
`endif
            if (rst) begin
                cur  = '{instr: 32'h0, pc: RPC, pred_pc: RPC + 4, addr: RPC, taken: 1'b0, vld: 1'b0, pc_dc: 1'b0};
                pc_m = RPC;
                for (int i = 0; i < BHT; i++) ctr[i] = 1;
            end else begin
                if (redirect) begin
                    cur.instr = 32'h0;
                    cur.vld   = 1'b0;
                    cur.taken = 1'b0;
                    cur.pc_dc = 1'b1;
                    pc_m      = redirect_pc;
                end else if (!stall) begin
                    cur  = '{instr: w, pc: pc_m, pred_pc: pn, addr: 32'h0, taken: pt, vld: 1'b1, pc_dc: 1'b0};
                    pc_m = pn;
                end
`ifdef FETCH_BP_EN
                if (br_vld) begin
                    int k;
                    k = (br_pc / 4) % BHT;
                    ctr[k] = br_taken ? ((ctr[k] < 3) ? ctr[k] + 1 : 3) : ((ctr[k] > 0) ? ctr[k] - 1 : 0);
                end
`endif
            end
            cur.addr = pc_m;
            q.push_back(cur);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
